// File: rtl/flash_sample_reader_if.sv
// Avalon-MM read-master bundle between the sample reader and the flash controller.
interface flash_sample_reader_if #(
  parameter int ADDR_W = 23,
  parameter int DATA_W = 32
);
  logic                flash_read;
  logic [ADDR_W-1:0]   flash_address;
  logic [DATA_W/8-1:0] flash_byteenable;
  logic                flash_waitrequest;
  logic [DATA_W-1:0]   flash_readdata;
  logic                flash_readdatavalid;

  modport master (
    output flash_read, flash_address, flash_byteenable,
    input  flash_waitrequest, flash_readdata, flash_readdatavalid
  );

  modport slave (
    input  flash_read, flash_address, flash_byteenable,
    output flash_waitrequest, flash_readdata, flash_readdatavalid
  );
endinterface

// File: rtl/flash_sample_reader.sv
// Streams packed samples from flash, one per sample_clk rising edge.
// Current word + one-word prefetch; fetch FSM keeps at most one read outstanding.
//
// state   | meaning
// F_IDLE  | no read in flight; launch one when the prefetch slot is empty
// F_REQ   | flash_read high, holding address until waitrequest drops
// F_WAIT  | handshake done, waiting for readdatavalid
// F_DRAIN | restart hit a read in flight; swallow its readdatavalid
module flash_sample_reader #(
  parameter int ADDR_W     = 23,
  parameter int DATA_W     = 32,
  parameter int SAMPLE_W   = 16,
  parameter int START_ADDR = 0,
  parameter int END_ADDR   = 'h7FFFF,
  parameter int LOOP       = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  sample_clk,
  input  logic                  pause,
  input  logic                  direction,
  input  logic                  restart,
  flash_sample_reader_if.master flash,
  output logic [SAMPLE_W-1:0]   sample_out,
  output logic                  sample_valid,
  output logic                  underrun,
  output logic                  done
);
  localparam int N     = DATA_W / SAMPLE_W;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [ADDR_W-1:0] START_A  = ADDR_W'(START_ADDR);
  localparam logic [ADDR_W-1:0] END_A    = ADDR_W'(END_ADDR);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N - 1);

  typedef enum logic [1:0] {F_IDLE, F_REQ, F_WAIT, F_DRAIN} fstate_t;

  logic [2:0]          sync_q;
  logic                tick_q, tick_ev;
  fstate_t             state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d, next_addr_q, next_addr_d, adv_addr;
  logic                end_q, end_d, fdir_q, fdir_d, drain_q, drain_d;
  logic                accept, at_bound, word_last;
  logic [DATA_W-1:0]   cur_data_q, cur_data_d, pf_data_q, pf_data_d;
  logic                cur_full_q, cur_full_d, pf_full_q, pf_full_d;
  logic                cur_dir_q, cur_dir_d, pf_dir_q, pf_dir_d;
  logic                cur_last_q, cur_last_d, pf_last_q, pf_last_d;
  logic [IDX_W-1:0]    idx_q, idx_d, lane_idx;
  logic [SAMPLE_W-1:0] sample_q, sample_d, lane_data;
  logic                valid_q, valid_d, under_q, under_d, done_q, done_d;

  assign tick_ev   = tick_q & ~pause & ~done_q & ~restart;
  assign at_bound  = fdir_q ? (addr_q == END_A) : (addr_q == START_A);
  assign adv_addr  = fdir_q ? (at_bound ? START_A : addr_q + 1'b1)
                            : (at_bound ? END_A   : addr_q - 1'b1);
  assign word_last = at_bound && (LOOP == 0);
  // Word fetched in reverse plays its top lane first.
  assign lane_idx  = cur_dir_q ? idx_q : LAST_IDX - idx_q;
  assign lane_data = cur_data_q[int'(lane_idx)*SAMPLE_W +: SAMPLE_W];

  assign flash.flash_read       = (state_q == F_REQ);
  assign flash.flash_address    = addr_q;
  assign flash.flash_byteenable = (state_q == F_REQ) ? '1 : '0;
  assign sample_out   = sample_q;
  assign sample_valid = valid_q;
  assign underrun     = under_q;
  assign done         = done_q;

  // Two-flop synchroniser plus edge-detect flop; tick is registered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      tick_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], sample_clk};
      tick_q <= sync_q[1] & ~sync_q[2];
    end
  end

  // Fetch FSM next state; restart re-aims the next fetch and drains any read in flight.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    fdir_d      = fdir_q;
    drain_d     = drain_q;
    next_addr_d = next_addr_q;
    end_d       = end_q;
    accept      = 1'b0;
    case (state_q)
      F_IDLE: begin
        drain_d = 1'b0;
        if (!restart && !pf_full_q && !done_q && !end_q) begin
          state_d = F_REQ;
          addr_d  = next_addr_q;
          fdir_d  = direction;
        end
      end
      F_REQ: begin
        if (restart) drain_d = 1'b1;
        if (!flash.flash_waitrequest) state_d = (drain_q || restart) ? F_DRAIN : F_WAIT;
      end
      F_WAIT: begin
        if (restart) begin
          state_d = flash.flash_readdatavalid ? F_IDLE : F_DRAIN;
        end else if (flash.flash_readdatavalid) begin
          accept      = 1'b1;
          state_d     = F_IDLE;
          next_addr_d = adv_addr;
          if (word_last) end_d = 1'b1;
        end
      end
      F_DRAIN: begin
        if (flash.flash_readdatavalid) state_d = F_IDLE;
      end
      default: state_d = F_IDLE;
    endcase
    if (restart) begin
      next_addr_d = direction ? START_A : END_A;
      end_d       = 1'b0;
    end
  end

  // Buffer and playback: tick consumes a lane, arriving data fills current or prefetch.
  always_comb begin
    cur_data_d = cur_data_q;
    cur_full_d = cur_full_q;
    cur_dir_d  = cur_dir_q;
    cur_last_d = cur_last_q;
    pf_data_d  = pf_data_q;
    pf_full_d  = pf_full_q;
    pf_dir_d   = pf_dir_q;
    pf_last_d  = pf_last_q;
    idx_d      = idx_q;
    sample_d   = sample_q;
    valid_d    = 1'b0;
    under_d    = 1'b0;
    done_d     = done_q;
    if (restart) begin
      cur_full_d = 1'b0;
      pf_full_d  = 1'b0;
      idx_d      = '0;
      done_d     = 1'b0;
    end else begin
      if (tick_ev) begin
        if (cur_full_q) begin
          sample_d = lane_data;
          valid_d  = 1'b1;
          if (idx_q == LAST_IDX) begin
            idx_d      = '0;
            if (cur_last_q) done_d = 1'b1;
            cur_full_d = pf_full_q;
            cur_data_d = pf_data_q;
            cur_dir_d  = pf_dir_q;
            cur_last_d = pf_last_q;
            pf_full_d  = 1'b0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          under_d = 1'b1;
        end
      end
      if (accept) begin
        if (!cur_full_d) begin
          cur_data_d = flash.flash_readdata;
          cur_full_d = 1'b1;
          cur_dir_d  = fdir_q;
          cur_last_d = word_last;
        end else begin
          pf_data_d  = flash.flash_readdata;
          pf_full_d  = 1'b1;
          pf_dir_d   = fdir_q;
          pf_last_d  = word_last;
        end
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= F_IDLE;
      addr_q      <= START_A;
      next_addr_q <= START_A;
      end_q       <= 1'b0;
      fdir_q      <= 1'b1;
      drain_q     <= 1'b0;
      cur_data_q  <= '0;
      cur_full_q  <= 1'b0;
      cur_dir_q   <= 1'b1;
      cur_last_q  <= 1'b0;
      pf_data_q   <= '0;
      pf_full_q   <= 1'b0;
      pf_dir_q    <= 1'b1;
      pf_last_q   <= 1'b0;
      idx_q       <= '0;
      sample_q    <= '0;
      valid_q     <= 1'b0;
      under_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      next_addr_q <= next_addr_d;
      end_q       <= end_d;
      fdir_q      <= fdir_d;
      drain_q     <= drain_d;
      cur_data_q  <= cur_data_d;
      cur_full_q  <= cur_full_d;
      cur_dir_q   <= cur_dir_d;
      cur_last_q  <= cur_last_d;
      pf_data_q   <= pf_data_d;
      pf_full_q   <= pf_full_d;
      pf_dir_q    <= pf_dir_d;
      pf_last_q   <= pf_last_d;
      idx_q       <= idx_d;
      sample_q    <= sample_d;
      valid_q     <= valid_d;
      under_q     <= under_d;
      done_q      <= done_d;
    end
  end
endmodule

// File: tb/tb_flash_sample_reader.sv
// Bench for flash_sample_reader: looping 4-word region (A) and one-shot single word (B).
module tb_flash_sample_reader;
  logic clk = 1'b0;
  always #10 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // DUT A: region 0..3, wrap
  logic        rst_a_n, sclk_a, pause_a, dir_a, restart_a;
  logic [15:0] a_sample;
  logic        a_valid, a_under, a_done;
  flash_sample_reader_if #(.ADDR_W(23), .DATA_W(32)) ifa ();
  flash_sample_reader #(.ADDR_W(23), .DATA_W(32), .SAMPLE_W(16),
                        .START_ADDR(0), .END_ADDR(3), .LOOP(1)) dut_a (
    .clk(clk), .reset_n(rst_a_n), .sample_clk(sclk_a), .pause(pause_a),
    .direction(dir_a), .restart(restart_a), .flash(ifa),
    .sample_out(a_sample), .sample_valid(a_valid), .underrun(a_under), .done(a_done));

  // DUT B: single word at 5, one-shot
  logic        rst_b_n, sclk_b, restart_b;
  logic        pause_b = 1'b0;
  logic        dir_b   = 1'b1;
  logic [15:0] b_sample;
  logic        b_valid, b_under, b_done;
  flash_sample_reader_if #(.ADDR_W(23), .DATA_W(32)) ifb ();
  flash_sample_reader #(.ADDR_W(23), .DATA_W(32), .SAMPLE_W(16),
                        .START_ADDR(5), .END_ADDR(5), .LOOP(0)) dut_b (
    .clk(clk), .reset_n(rst_b_n), .sample_clk(sclk_b), .pause(pause_b),
    .direction(dir_b), .restart(restart_b), .flash(ifb),
    .sample_out(b_sample), .sample_valid(b_valid), .underrun(b_under), .done(b_done));

  // Flash contents and slave behaviour knobs
  logic [31:0] a_mem [4];
  logic [31:0] b_mem [8];
  int          a_wait = 0;
  int          a_lat  = 2;
  bit          a_in_wait = 1'b0;
  int          a_hs_bad = 0;
  int          a_be_bad = 0;
  logic [22:0] a_log [$];
  logic [22:0] b_log [$];
  logic [15:0] a_samp [$];
  logic [15:0] b_samp [$];
  int          a_under_cnt = 0;
  int          b_under_cnt = 0;

  // Flash slave A: optional waitrequest stretch, programmable read latency.
  initial begin
    logic [22:0] ad;
    ifa.flash_waitrequest   = 1'b1;
    ifa.flash_readdatavalid = 1'b0;
    ifa.flash_readdata      = '0;
    forever begin
      @(negedge clk);
      if (ifa.flash_read === 1'b1) begin
        ad = ifa.flash_address;
        repeat (a_wait) begin
          @(negedge clk);
          if (ifa.flash_read !== 1'b1 || ifa.flash_address !== ad) a_hs_bad++;
        end
        a_log.push_back(ad);
        ifa.flash_waitrequest = 1'b0;
        @(negedge clk);
        ifa.flash_waitrequest = 1'b1;
        a_in_wait = 1'b1;
        if (ifa.flash_read !== 1'b0) a_hs_bad++;
        repeat (a_lat) @(negedge clk);
        ifa.flash_readdata      = a_mem[ad[1:0]];
        ifa.flash_readdatavalid = 1'b1;
        @(negedge clk);
        ifa.flash_readdatavalid = 1'b0;
        ifa.flash_readdata      = $urandom;
        a_in_wait = 1'b0;
      end
    end
  end

  // Flash slave B: immediate accept, one-cycle latency.
  initial begin
    logic [22:0] ad;
    ifb.flash_waitrequest   = 1'b1;
    ifb.flash_readdatavalid = 1'b0;
    ifb.flash_readdata      = '0;
    forever begin
      @(negedge clk);
      if (ifb.flash_read === 1'b1) begin
        ad = ifb.flash_address;
        b_log.push_back(ad);
        ifb.flash_waitrequest = 1'b0;
        @(negedge clk);
        ifb.flash_waitrequest = 1'b1;
        @(negedge clk);
        ifb.flash_readdata      = b_mem[ad[2:0]];
        ifb.flash_readdatavalid = 1'b1;
        @(negedge clk);
        ifb.flash_readdatavalid = 1'b0;
      end
    end
  end

  // Output monitors
  always @(negedge clk) begin
    if (a_valid === 1'b1) a_samp.push_back(a_sample);
    if (a_under === 1'b1) a_under_cnt++;
    if (b_valid === 1'b1) b_samp.push_back(b_sample);
    if (b_under === 1'b1) b_under_cnt++;
    if (ifa.flash_read === 1'b1 && ifa.flash_byteenable !== 4'hF) a_be_bad++;
    if (ifa.flash_read === 1'b0 && ifa.flash_byteenable !== 4'h0) a_be_bad++;
  end

  // Reference model: sample stream from the region rules, not from the RTL.
  function automatic logic [15:0] lane_of(logic [31:0] w, int k);
    return w[k*16 +: 16];
  endfunction

  function automatic logic [15:0] exp_a(int start, bit fwd, int i);
    int w, addr;
    w    = i / 2;
    addr = fwd ? (start + w) % 4 : (start + 4 - (w % 4)) % 4;
    return fwd ? lane_of(a_mem[addr], i % 2) : lane_of(a_mem[addr], 1 - (i % 2));
  endfunction

  task automatic tick_a();
    sclk_a = 1'b1;
    repeat (6) @(negedge clk);
    sclk_a = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic tick_b();
    sclk_b = 1'b1;
    repeat (6) @(negedge clk);
    sclk_b = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic pulse_restart_a();
    restart_a = 1'b1;
    @(negedge clk);
    restart_a = 1'b0;
  endtask

  task automatic wait_a_in_wait(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (a_in_wait) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic check_a_stream(string name, int sb, int n, int start, bit fwd);
    n_tests++;
    if (a_samp.size() - sb !== n) begin
      n_fail++;
      $display("FAIL %s count: got %0d want %0d", name, a_samp.size() - sb, n);
    end
    for (int i = 0; i < n && sb + i < a_samp.size(); i++) begin
      n_tests++;
      if (a_samp[sb+i] !== exp_a(start, fwd, i)) begin
        n_fail++;
        $display("FAIL %s sample %0d: got %h want %h", name, i, a_samp[sb+i], exp_a(start, fwd, i));
      end
    end
  endtask

  task automatic test_reset();
    n_tests++; if (ifa.flash_read !== 1'b0) begin n_fail++; $display("FAIL reset read: got %b want 0", ifa.flash_read); end
    n_tests++; if (ifa.flash_address !== 23'd0) begin n_fail++; $display("FAIL reset addr: got %h want 0", ifa.flash_address); end
    n_tests++; if (a_sample !== 16'h0) begin n_fail++; $display("FAIL reset sample: got %h want 0", a_sample); end
    n_tests++; if (a_valid !== 1'b0) begin n_fail++; $display("FAIL reset valid: got %b want 0", a_valid); end
    n_tests++; if (a_under !== 1'b0) begin n_fail++; $display("FAIL reset underrun: got %b want 0", a_under); end
    n_tests++; if (a_done !== 1'b0) begin n_fail++; $display("FAIL reset done: got %b want 0", a_done); end
    n_tests++; if (ifb.flash_address !== 23'd5) begin n_fail++; $display("FAIL reset addr B: got %h want 5", ifb.flash_address); end
  endtask

  task automatic test_forward();
    int sb, ub;
    repeat (30) @(negedge clk);
    sb = a_samp.size();
    ub = a_under_cnt;
    repeat (10) tick_a();
    check_a_stream("forward", sb, 10, 0, 1'b1);
    n_tests++;
    if (a_under_cnt !== ub) begin n_fail++; $display("FAIL forward underrun: got %0d want 0", a_under_cnt - ub); end
    for (int i = 0; i < a_log.size(); i++) begin
      n_tests++;
      if (a_log[i] !== 23'(i % 4)) begin n_fail++; $display("FAIL forward addr %0d: got %h want %h", i, a_log[i], i % 4); end
    end
    repeat (20) @(negedge clk);
  endtask

  task automatic test_pause();
    int sb, ub;
    sb = a_samp.size();
    ub = a_under_cnt;
    pause_a = 1'b1;
    repeat (2) tick_a();
    pause_a = 1'b0;
    n_tests++;
    if (a_samp.size() != sb || a_under_cnt != ub) begin
      n_fail++;
      $display("FAIL pause: got %0d samples %0d underruns want 0 0", a_samp.size() - sb, a_under_cnt - ub);
    end
  endtask

  task automatic test_reverse();
    int sb, lb;
    dir_a = 1'b0;
    lb = a_log.size();
    sb = a_samp.size();
    pulse_restart_a();
    repeat (30) @(negedge clk);
    sb = a_samp.size();
    repeat (10) tick_a();
    check_a_stream("reverse", sb, 10, 3, 1'b0);
    for (int i = lb; i < a_log.size(); i++) begin
      n_tests++;
      if (a_log[i] !== 23'((3 + 4 - ((i - lb) % 4)) % 4)) begin
        n_fail++;
        $display("FAIL reverse addr %0d: got %h want %h", i - lb, a_log[i], (3 + 4 - ((i - lb) % 4)) % 4);
      end
    end
    repeat (20) @(negedge clk);
  endtask

  task automatic test_waitrequest();
    int lb, hb, bb, sb;
    dir_a  = 1'b1;
    a_wait = 5;
    lb = a_log.size();
    hb = a_hs_bad;
    bb = a_be_bad;
    pulse_restart_a();
    repeat (60) @(negedge clk);
    sb = a_samp.size();
    repeat (2) tick_a();
    check_a_stream("waitreq", sb, 2, 0, 1'b1);
    n_tests++;
    if (a_hs_bad !== hb) begin n_fail++; $display("FAIL waitreq handshake: got %0d violations want 0", a_hs_bad - hb); end
    n_tests++;
    if (a_be_bad !== bb) begin n_fail++; $display("FAIL waitreq byteenable: got %0d violations want 0", a_be_bad - bb); end
    n_tests++;
    if (a_log.size() < lb + 2 || a_log[lb] !== 23'd0 || a_log[lb+1] !== 23'd1) begin
      n_fail++; $display("FAIL waitreq addr: got %0d reads want first 0,1", a_log.size() - lb);
    end
    a_wait = 0;
    repeat (60) @(negedge clk);
  endtask

  task automatic test_underrun();
    logic [15:0] held;
    int sb, ub;
    a_lat = 40;
    held = a_sample;
    sb = a_samp.size();
    ub = a_under_cnt;
    pulse_restart_a();
    repeat (3) tick_a();
    n_tests++;
    if (a_under_cnt - ub !== 3) begin n_fail++; $display("FAIL underrun count: got %0d want 3", a_under_cnt - ub); end
    n_tests++;
    if (a_samp.size() !== sb) begin n_fail++; $display("FAIL underrun valid: got %0d pulses want 0", a_samp.size() - sb); end
    n_tests++;
    if (a_sample !== held) begin n_fail++; $display("FAIL underrun hold: got %h want %h", a_sample, held); end
    repeat (100) @(negedge clk);
    sb = a_samp.size();
    repeat (4) tick_a();
    check_a_stream("underrun resume", sb, 4, 0, 1'b1);
    a_lat = 2;
    repeat (100) @(negedge clk);
  endtask

  task automatic test_restart_drain();
    bit ok;
    int lb, sb;
    a_lat = 20;
    dir_a = 1'b1;
    pulse_restart_a();
    wait_a_in_wait(ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL drain reach F_WAIT: got timeout want read in flight"); end
    lb = a_log.size();
    dir_a = 1'b0;
    pulse_restart_a();
    repeat (100) @(negedge clk);
    sb = a_samp.size();
    repeat (4) tick_a();
    check_a_stream("drain", sb, 4, 3, 1'b0);
    n_tests++;
    if (a_log.size() <= lb || a_log[lb] !== 23'd3) begin
      n_fail++; $display("FAIL drain next addr: got %0d reads want first at 3", a_log.size() - lb);
    end
    a_lat = 2;
    dir_a = 1'b1;
    repeat (60) @(negedge clk);
  endtask

  task automatic test_oneshot();
    int sb, ub;
    sb = b_samp.size();
    ub = b_under_cnt;
    repeat (3) tick_b();
    n_tests++;
    if (b_samp.size() - sb !== 2) begin n_fail++; $display("FAIL oneshot count: got %0d want 2", b_samp.size() - sb); end
    n_tests++;
    if (b_samp.size() >= sb + 2 && (b_samp[sb] !== lane_of(b_mem[5], 0) || b_samp[sb+1] !== lane_of(b_mem[5], 1))) begin
      n_fail++; $display("FAIL oneshot samples: got %h %h want %h %h", b_samp[sb], b_samp[sb+1], lane_of(b_mem[5], 0), lane_of(b_mem[5], 1));
    end
    n_tests++;
    if (b_done !== 1'b1) begin n_fail++; $display("FAIL oneshot done: got %b want 1", b_done); end
    n_tests++;
    if (b_under_cnt !== ub) begin n_fail++; $display("FAIL oneshot underrun: got %0d want 0", b_under_cnt - ub); end
    n_tests++;
    if (b_log.size() !== 1 || b_log[0] !== 23'd5) begin n_fail++; $display("FAIL oneshot reads: got %0d want 1 at 5", b_log.size()); end
    restart_b = 1'b1;
    @(negedge clk);
    restart_b = 1'b0;
    n_tests++;
    if (b_done !== 1'b0) begin n_fail++; $display("FAIL restart done: got %b want 0", b_done); end
    repeat (20) @(negedge clk);
    n_tests++;
    if (b_log.size() !== 2 || b_log[1] !== 23'd5) begin n_fail++; $display("FAIL restart reads: got %0d want 2 at 5", b_log.size()); end
    sb = b_samp.size();
    tick_b();
    n_tests++;
    if (b_samp.size() !== sb + 1 || b_sample !== lane_of(b_mem[5], 0)) begin
      n_fail++; $display("FAIL restart sample: got %h want %h", b_sample, lane_of(b_mem[5], 0));
    end
  endtask

  task automatic test_reset_midread();
    bit ok;
    int sb;
    a_lat = 20;
    pulse_restart_a();
    wait_a_in_wait(ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL midread reach F_WAIT: got timeout want read in flight"); end
    rst_a_n = 1'b0;
    #1;
    n_tests++; if (ifa.flash_read !== 1'b0) begin n_fail++; $display("FAIL midread read: got %b want 0", ifa.flash_read); end
    n_tests++; if (ifa.flash_address !== 23'd0) begin n_fail++; $display("FAIL midread addr: got %h want 0", ifa.flash_address); end
    n_tests++; if (a_sample !== 16'h0) begin n_fail++; $display("FAIL midread sample: got %h want 0", a_sample); end
    n_tests++; if (a_valid !== 1'b0 || a_under !== 1'b0 || a_done !== 1'b0) begin n_fail++; $display("FAIL midread flags: got %b%b%b want 000", a_valid, a_under, a_done); end
    @(negedge clk);
    rst_a_n = 1'b1;
    a_lat = 2;
    repeat (80) @(negedge clk);
    sb = a_samp.size();
    repeat (2) tick_a();
    check_a_stream("after reset", sb, 2, 0, 1'b1);
  endtask

  initial begin
    a_mem[0] = 32'hBBBB_AAAA;
    a_mem[1] = 32'hDDDD_CCCC;
    a_mem[2] = $urandom;
    a_mem[3] = $urandom;
    for (int i = 0; i < 8; i++) b_mem[i] = $urandom;
    rst_a_n = 1'b0; rst_b_n = 1'b0;
    sclk_a = 1'b0; sclk_b = 1'b0;
    pause_a = 1'b0; dir_a = 1'b1;
    restart_a = 1'b0; restart_b = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_a_n = 1'b1;
    rst_b_n = 1'b1;
    test_forward();
    test_pause();
    test_reverse();
    test_waitrequest();
    test_underrun();
    test_restart_drain();
    test_oneshot();
    test_reset_midread();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
